mux2_1_exerciser: RTL and testbench

Self-checking sequencer that sits directly upstream of `mux2_1`. It drives the mux's `i0`, `i1` and `s` inputs and consumes its `y` output. On a `start` request it steps through all eight input combinations and waits a programmable settle time before each comparison. It then checks `y` against a golden 2:1 select and reports pass/fail, an error count and a per-vector failure mask. It replaces the open-loop `$monitor` stimulus with a clocked, reusable on-chip checker.

---
 rtl/mux2_1_exerciser_pkg.sv | 8 +
 rtl/mux2_1_exerciser_if.sv | 9 +
 rtl/mux2_1_exerciser_mux.sv | 9 +
 rtl/mux2_1_exerciser.sv | 117 +++++++++++
 tb/tb_mux2_1_exerciser.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/mux2_1_exerciser_pkg.sv
// mux_test_pkg: shared FSM state type and sizing constants for the mux2_1 exerciser.
package mux_test_pkg;
    typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_e;
    localparam int VEC_W = 3;
    localparam int N_VEC = 8;
    localparam int ERR_W = 4;
    localparam int CNT_W = 4;
endpackage

// File: rtl/mux2_1_exerciser_if.sv
// mux2_1_exerciser_if: stimulus/response bus between the exerciser and the mux under test.
interface mux2_1_exerciser_if;
    logic i0;
    logic i1;
    logic s;
    logic y;
    modport master (output i0, i1, s, input y);
    modport slave (input i0, i1, s, output y);
endinterface

// File: rtl/mux2_1_exerciser_mux.sv
// mux2_1: reference 2:1 multiplexer, used as the golden model inside the exerciser.
module mux2_1 (
    input  logic i0_i,
    input  logic i1_i,
    input  logic s_i,
    output logic y_o
);
    assign y_o = s_i ? i1_i : i0_i;
endmodule

// File: rtl/mux2_1_exerciser.sv
// mux2_1_exerciser: walks all eight {i0,i1,s} vectors through a mux and checks y after a settle time.
module mux2_1_exerciser
    import mux_test_pkg::*;
#(
    parameter int unsigned SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    mux2_1_exerciser_if.master   mux_if,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 pass_o,
    output logic [ERR_W-1:0]     err_count_o,
    output logic [N_VEC-1:0]     fail_mask_o
);
    state_e            state_q, state_d;
    logic [VEC_W-1:0]  vec_q, vec_d;
    logic [VEC_W-1:0]  drv_q, drv_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ERR_W-1:0]  err_q, err_d;
    logic [N_VEC-1:0]  mask_q, mask_d;
    logic              pass_q, pass_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              exp_y;
    logic              miss;

    // Golden value comes from the registered drive, so it always matches what the mux sees.
    mux2_1 u_gold (
        .i0_i (drv_q[2]),
        .i1_i (drv_q[1]),
        .s_i  (drv_q[0]),
        .y_o  (exp_y)
    );

    assign miss = mux_if.y != exp_y;

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        drv_d   = drv_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        mask_d  = mask_q;
        pass_d  = pass_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = mux_test_pkg::SETTLE;
                    vec_d   = '0;
                    drv_d   = '0;
                    cnt_d   = '0;
                    err_d   = '0;
                    mask_d  = '0;
                    pass_d  = 1'b0;
                end
            end
            mux_test_pkg::SETTLE: begin
                cnt_d   = cnt_q + 1'b1;
                state_d = (cnt_q == CNT_W'(SETTLE - 1)) ? CHECK : mux_test_pkg::SETTLE;
            end
            CHECK: begin
                if (miss) begin
                    err_d         = err_q + 1'b1;
                    mask_d[vec_q] = 1'b1;
                end
                if (vec_q == VEC_W'(N_VEC - 1)) begin
                    state_d = DONE;
                    pass_d  = (err_d == '0);
                end else begin
                    state_d = mux_test_pkg::SETTLE;
                    vec_d   = vec_q + 1'b1;
                    drv_d   = vec_q + 1'b1;
                    cnt_d   = '0;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == mux_test_pkg::SETTLE) || (state_d == CHECK);
        done_d = state_d == DONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            vec_q   <= '0;
            drv_q   <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
            mask_q  <= '0;
            pass_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            drv_q   <= drv_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            mask_q  <= mask_d;
            pass_q  <= pass_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign mux_if.i0   = drv_q[2];
    assign mux_if.i1   = drv_q[1];
    assign mux_if.s    = drv_q[0];
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign pass_o      = pass_q;
    assign err_count_o = err_q;
    assign fail_mask_o = mask_q;
endmodule

// File: tb/tb_mux2_1_exerciser.sv
// tb_mux2_1_exerciser: scoreboard bench for two exercisers (SETTLE=1 and SETTLE=3) driving faultable muxes.
module tb_mux2_1_exerciser;
    typedef struct {
        int         inst;
        logic       pass;
        int         err;
        logic [7:0] mask;
        int         done_cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start [2];
    int         mode [2];
    logic       busy [2];
    logic       done [2];
    logic       pass [2];
    logic [3:0] errc [2];
    logic [7:0] mask [2];
    logic [2:0] vout [2];
    int         cyc = 0;
    int         n_vec = 0;
    int         n_bad = 0;
    exp_t       q[$];
    exp_t       mon_e;

    mux2_1_exerciser_if ifa ();
    mux2_1_exerciser_if ifb ();

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Mode 0 is a healthy mux; 1/2 stuck-at-0/1; 3 inverted output.
    function automatic logic mux_model(int m, logic a, logic b, logic sel);
        logic g;
        g = sel ? b : a;
        return (m == 1) ? 1'b0 : (m == 2) ? 1'b1 : (m == 3) ? ~g : g;
    endfunction

    always_comb ifa.y = mux_model(mode[0], ifa.i0, ifa.i1, ifa.s);
    always_comb ifb.y = mux_model(mode[1], ifb.i0, ifb.i1, ifb.s);
    assign vout[0] = {ifa.i0, ifa.i1, ifa.s};
    assign vout[1] = {ifb.i0, ifb.i1, ifb.s};

    mux2_1_exerciser #(.SETTLE(1)) dut_a (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start[0]),
        .mux_if      (ifa),
        .busy_o      (busy[0]),
        .done_o      (done[0]),
        .pass_o      (pass[0]),
        .err_count_o (errc[0]),
        .fail_mask_o (mask[0])
    );

    mux2_1_exerciser #(.SETTLE(3)) dut_b (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start[1]),
        .mux_if      (ifb),
        .busy_o      (busy[1]),
        .done_o      (done[1]),
        .pass_o      (pass[1]),
        .err_count_o (errc[1]),
        .fail_mask_o (mask[1])
    );

    function automatic exp_t model(int j, int m, int c);
        exp_t e;
        e.inst = j;
        e.err  = 0;
        e.mask = '0;
        for (int v = 0; v < 8; v++) begin
            logic [2:0] vb;
            logic       golden;
            vb     = 3'(v);
            golden = vb[0] ? vb[1] : vb[2];
            if (mux_model(m, vb[2], vb[1], vb[0]) != golden) begin
                e.err++;
                e.mask[v] = 1'b1;
            end
        end
        e.pass     = (e.err == 0);
        e.done_cyc = c + 1 + 8 * (((j == 0) ? 1 : 3) + 1);
        return e;
    endfunction

    task automatic chk(string name, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        for (int j = 0; j < 2; j++) begin
            if (done[j] === 1'b1) begin
                chk("done_expected", int'(q.size() > 0), 1);
                if (q.size() > 0) begin
                    mon_e = q.pop_front();
                    chk("done_inst", j, mon_e.inst);
                    chk("pass", int'(pass[j]), int'(mon_e.pass));
                    chk("err_count", int'(errc[j]), mon_e.err);
                    chk("fail_mask", int'(mask[j]), int'(mon_e.mask));
                    chk("done_cycle", cyc, mon_e.done_cyc);
                    chk("busy_at_done", int'(busy[j]), 0);
                    chk("hold_vec7", int'(vout[j]), 7);
                end
            end
        end
    end

    task automatic drain(int budget);
        int t = 0;
        while (q.size() > 0 && t < budget) begin
            @(negedge clk);
            t++;
        end
        chk("drain_timeout", q.size(), 0);
        q.delete();
        @(negedge clk);
    endtask

    task automatic launch(int j, int m);
        mode[j]  = m;
        start[j] = 1'b1;
        q.push_back(model(j, m, cyc));
        @(negedge clk);
        start[j] = 1'b0;
        chk("busy_after_start", int'(busy[j]), 1);
        chk("vec0_loaded", int'(vout[j]), 0);
        chk("err_cleared", int'(errc[j]), 0);
        chk("mask_cleared", int'(mask[j]), 0);
        chk("pass_cleared", int'(pass[j]), 0);
    endtask

    task automatic chk_reset(int j);
        chk("rst_busy", int'(busy[j]), 0);
        chk("rst_done", int'(done[j]), 0);
        chk("rst_pass", int'(pass[j]), 0);
        chk("rst_err", int'(errc[j]), 0);
        chk("rst_mask", int'(mask[j]), 0);
        chk("rst_vec", int'(vout[j]), 0);
    endtask

    initial begin
        int c;
        int j;
        start = '{1'b0, 1'b0};
        mode  = '{0, 0};
        rst   = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset(0);
        chk_reset(1);
        rst = 1'b0;
        @(negedge clk);
        for (int m = 0; m < 4; m++) begin
            launch(0, m);
            drain(40);
        end
        launch(1, 3);
        drain(60);
        launch(1, 0);
        drain(60);
        // start pulsed mid-run must be ignored
        launch(0, 0);
        repeat (5) @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        drain(40);
        // start held: second run starts from IDLE one cycle after done
        c = cyc;
        mode[0]  = 1;
        start[0] = 1'b1;
        q.push_back(model(0, 1, c));
        q.push_back(model(0, 0, c + 18));
        repeat (18) @(negedge clk);
        mode[0] = 0;
        @(negedge clk);
        chk("held_busy", int'(busy[0]), 1);
        chk("held_err_cleared", int'(errc[0]), 0);
        chk("held_mask_cleared", int'(mask[0]), 0);
        chk("held_vec0", int'(vout[0]), 0);
        start[0] = 1'b0;
        drain(60);
        // reset while vector 4 is applied
        launch(0, 0);
        repeat (8) @(negedge clk);
        chk("vec4_applied", int'(vout[0]), 4);
        chk("vec4_busy", int'(busy[0]), 1);
        rst = 1'b1;
        q.delete();
        @(negedge clk);
        chk_reset(0);
        rst = 1'b0;
        repeat (25) @(negedge clk);
        launch(0, 0);
        drain(40);
        for (int i = 0; i < 10; i++) begin
            j = int'($urandom_range(0, 1));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            launch(j, int'($urandom_range(0, 3)));
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 10)) @(negedge clk);
                start[j] = 1'b1;
                @(negedge clk);
                start[j] = 1'b0;
            end
            drain(80);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end
endmodule
